decode_queue: RTL

Multi-lane decode stage with an instruction buffer, between fetch and issue in the pipelined RV64 core. It accepts fetch bundles of up to IN_WIDTH instructions and decodes each one into `control_t` on entry. Decoded entries sit in a DEPTH-entry circular buffer. Up to OUT_WIDTH entries per cycle are presented to issue under a valid/ready handshake, with flush, illegal-instruction flagging and a control-flow grouping rule.

---
 rtl/pipes.sv | 95 +++++++++
 rtl/decode_unit.sv | 133 +++++++++++++
 rtl/decode_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipes.sv
// Shared decode types for the RV64 pipeline: opcodes, control word, ALU ops, queue entry.
// DECODE_MEXT_EN adds the RV64M ALU operations to alufunc_t.
package pipes;

  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_IW    = 7'b0011011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
`ifdef DECODE_MEXT_EN
    , ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    , ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
`endif
  } alufunc_t;

  typedef enum logic [3:0] {
    BRANCH_NONE, BRANCH_BEQ, BRANCH_BNE, BRANCH_BLT, BRANCH_BGE,
    BRANCH_BLTU, BRANCH_BGEU, BRANCH_JAL, BRANCH_JALR
  } branch_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  typedef struct packed {
    alufunc_t   alufunc;
    logic       selectA;    // operand A is the PC
    logic       selectB;    // operand B is the immediate
    logic       extAluOut;  // sign-extend the low 32 bits of the result
    branch_t    branch;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [2:0] memFunct3;
    imm_t       immType;
  } control_t;

  typedef struct packed {
    control_t    ctl;
    logic [63:0] pc;
    logic        illegal;
  } decode_entry_t;

  localparam int CTL_W = $bits(control_t);

  function automatic alufunc_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

`ifdef DECODE_MEXT_EN
  function automatic alufunc_t mext_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction
`endif

endpackage

// File: rtl/decode_unit.sv
// Combinational RV64 decoder: raw instruction -> control word plus illegal flag.
// DECODE_MEXT_EN enables RV64M decoding; otherwise those encodings are illegal.
module decode_unit
  import pipes::*;
(
  input  logic [31:0]      instr,
  output logic [CTL_W-1:0] ctl,
  output logic             illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  control_t   c;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    c     = '0;
    legal = 1'b0;
    case (opcode)
      OP_ITYPE: begin
        c.selectB = 1'b1; c.regWrite = 1'b1; c.immType = IMM_I;
        c.alufunc = alu_from_f3(f3, 1'b0);
        legal = 1'b1;
        if (f3 == F3_SLL) legal = (instr[31:26] == 6'b000000);
        if (f3 == F3_SR) begin
          legal = ({instr[31], instr[29:26]} == 5'b00000);
          c.alufunc = instr[30] ? ALU_SRA : ALU_SRL;
        end
      end
      OP_IW: begin
        c.selectB = 1'b1; c.regWrite = 1'b1; c.immType = IMM_I; c.extAluOut = 1'b1;
        c.alufunc = alu_from_f3(f3, f7 == F7_ALT);
        case (f3)
          F3_ADD:  legal = 1'b1;
          F3_SLL:  legal = (f7 == F7_BASE);
          F3_SR:   legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: legal = 1'b0;
        endcase
      end
      OP_RTYPE: begin
        c.regWrite = 1'b1;
        case (f7)
          F7_BASE: begin legal = 1'b1; c.alufunc = alu_from_f3(f3, 1'b0); end
          F7_ALT: begin
            legal = (f3 == F3_ADD) || (f3 == F3_SR);
            c.alufunc = alu_from_f3(f3, 1'b1);
          end
`ifdef DECODE_MEXT_EN
          F7_MEXT: begin legal = 1'b1; c.alufunc = mext_from_f3(f3); end
`endif
          default: legal = 1'b0;
        endcase
      end
      OP_RW: begin
        c.regWrite = 1'b1; c.extAluOut = 1'b1;
        case (f7)
          F7_BASE: begin
            legal = (f3 == F3_ADD) || (f3 == F3_SLL) || (f3 == F3_SR);
            c.alufunc = alu_from_f3(f3, 1'b0);
          end
          F7_ALT: begin
            legal = (f3 == F3_ADD) || (f3 == F3_SR);
            c.alufunc = alu_from_f3(f3, 1'b1);
          end
`ifdef DECODE_MEXT_EN
          F7_MEXT: begin
            legal = 1'b1;
            case (f3)
              3'b000:  c.alufunc = ALU_MULW;
              3'b100:  c.alufunc = ALU_DIVW;
              3'b101:  c.alufunc = ALU_DIVUW;
              3'b110:  c.alufunc = ALU_REMW;
              3'b111:  c.alufunc = ALU_REMUW;
              default: legal = 1'b0;
            endcase
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        legal = 1'b1; c.branch = BRANCH_JAL; c.selectA = 1'b1;
        c.regWrite = 1'b1; c.immType = IMM_J; c.alufunc = ALU_ADD;
      end
      OP_JALR: begin
        legal = (f3 == 3'b000); c.branch = BRANCH_JALR; c.selectB = 1'b1;
        c.regWrite = 1'b1; c.immType = IMM_I; c.alufunc = ALU_ADD;
      end
      OP_BTYPE: begin
        legal = 1'b1; c.alufunc = ALU_SUB; c.immType = IMM_B;
        case (f3)
          3'b000:  c.branch = BRANCH_BEQ;
          3'b001:  c.branch = BRANCH_BNE;
          3'b100:  c.branch = BRANCH_BLT;
          3'b101:  c.branch = BRANCH_BGE;
          3'b110:  c.branch = BRANCH_BLTU;
          3'b111:  c.branch = BRANCH_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OP_AUIPC: begin
        legal = 1'b1; c.selectA = 1'b1; c.selectB = 1'b1;
        c.regWrite = 1'b1; c.immType = IMM_U; c.alufunc = ALU_ADD;
      end
      OP_LUI: begin
        legal = 1'b1; c.selectB = 1'b1; c.regWrite = 1'b1;
        c.immType = IMM_U; c.alufunc = ALU_PASSB;
      end
      OP_LOAD: begin
        legal = (f3 != 3'b111); c.memRead = 1'b1; c.regWrite = 1'b1;
        c.selectB = 1'b1; c.immType = IMM_I; c.memFunct3 = f3; c.alufunc = ALU_ADD;
      end
      OP_STORE: begin
        legal = (f3[2] == 1'b0); c.memWrite = 1'b1; c.selectB = 1'b1;
        c.immType = IMM_S; c.memFunct3 = f3; c.alufunc = ALU_ADD;
      end
      default: legal = 1'b0;
    endcase
    // Unrecognised encodings still flow to commit, but with an inert control word.
    if (!legal) c = '0;
  end

  assign ctl     = c;
  assign illegal = ~legal;

endmodule

// File: rtl/decode_queue.sv
// Multi-lane decode stage: decodes fetch bundles into a circular buffer and issues
// up to OUT_WIDTH entries per cycle, ending each group at the first branch/jump.
module decode_queue
  import pipes::*;
#(
  parameter int DEPTH     = 8,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_mask,
  input  logic [IN_WIDTH*32-1:0]     in_instr,
  input  logic [IN_WIDTH*64-1:0]     in_pc,
  output logic [OUT_WIDTH-1:0]       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH*CTL_W-1:0] out_ctl,
  output logic [OUT_WIDTH*64-1:0]    out_pc,
  output logic [OUT_WIDTH-1:0]       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]    enq_cnt, deq_cnt;
  logic             enq;
  decode_entry_t    mem_q [DEPTH];
  logic [CTL_W-1:0] dec_ctl [IN_WIDTH];
  logic [IN_WIDTH-1:0] dec_ill;
  logic [IN_WIDTH-1:0] wr_en;
  logic [AW-1:0]    wr_idx [IN_WIDTH];
  decode_entry_t    wr_entry [IN_WIDTH];
  logic [AW-1:0]    rd_idx;
  decode_entry_t    rd_entry;
  logic             blocked;

  for (genvar g = 0; g < IN_WIDTH; g++) begin : g_dec
    decode_unit u_dec (
      .instr   (in_instr[g*32 +: 32]),
      .ctl     (dec_ctl[g]),
      .illegal (dec_ill[g])
    );
  end

  // Pointers carry a wrap bit, so tail - head is the occupancy even when full.
  assign count    = tail_q - head_q;
  assign in_ready = (count <= PW'(DEPTH - IN_WIDTH));
  assign enq      = in_valid && in_ready && !flush;

  // Enqueue side: lanes are contiguous from 0, so lane i lands at tail + i.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      wr_en[i]            = enq && in_mask[i];
      wr_idx[i]           = AW'(tail_q + PW'(i));
      wr_entry[i].ctl     = control_t'(dec_ctl[i]);
      wr_entry[i].pc      = in_pc[i*64 +: 64];
      wr_entry[i].illegal = dec_ill[i];
      if (in_mask[i]) enq_cnt = enq_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= wr_entry[i];
    end
  end

  // Issue window: a branch or jump closes the group in its own lane.
  always_comb begin
    out_valid   = '0;
    out_ctl     = '0;
    out_pc      = '0;
    out_illegal = '0;
    deq_cnt     = '0;
    blocked     = 1'b0;
    rd_idx      = '0;
    rd_entry    = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      rd_idx   = AW'(head_q + PW'(k));
      rd_entry = mem_q[rd_idx];
      if ((PW'(k) < count) && !blocked) begin
        out_valid[k]              = 1'b1;
        out_ctl[k*CTL_W +: CTL_W] = rd_entry.ctl;
        out_pc[k*64 +: 64]        = rd_entry.pc;
        out_illegal[k]            = rd_entry.illegal;
        deq_cnt                   = deq_cnt + PW'(1);
        if (rd_entry.ctl.branch != BRANCH_NONE) blocked = 1'b1;
      end
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (out_ready) head_d = head_q + deq_cnt;
      if (enq)       tail_d = tail_q + enq_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule
